// File: rtl/csr_exec_if.sv
// CSR execution unit bus: request, CSR-file access and writeback response.
interface csr_exec_if;
  // request
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_csr_i;
  logic [4:0]  req_rs1_idx_i;
  logic [31:0] req_rs1_val_i;
  logic [4:0]  req_rd_idx_i;
  // CSR file
  logic [11:0] csr_rs_o;
  logic [31:0] csr_out_i;
  logic [11:0] csr_rd_o;
  logic [31:0] csr_in_o;
  logic        csr_we_o;
  // writeback response
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [4:0]  resp_rd_idx_o;
  logic [31:0] resp_data_o;
  logic        resp_rd_we_o;
  logic        resp_illegal_o;

  modport slave (
    input  req_valid_i, req_funct3_i, req_csr_i, req_rs1_idx_i, req_rs1_val_i,
           req_rd_idx_i, csr_out_i, resp_ready_i,
    output req_ready_o, csr_rs_o, csr_rd_o, csr_in_o, csr_we_o,
           resp_valid_o, resp_rd_idx_o, resp_data_o, resp_rd_we_o, resp_illegal_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_csr_i, req_rs1_idx_i, req_rs1_val_i,
           req_rd_idx_i, csr_out_i, resp_ready_i,
    input  req_ready_o, csr_rs_o, csr_rd_o, csr_in_o, csr_we_o,
           resp_valid_o, resp_rd_idx_o, resp_data_o, resp_rd_we_o, resp_illegal_o
  );
endinterface

// File: rtl/csr_exec.sv
// CSR instruction executor: read old value, compute and write new value,
// return the old value to writeback. One request in flight at a time.
module csr_exec #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic      clk_i,
  input  logic      reset_i,
  csr_exec_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_funct3;
  logic [11:0] r_csr;
  logic [4:0]  r_rs1_idx;
  logic [31:0] r_rs1_val;
  logic [4:0]  r_rd_idx;
  logic [31:0] r_old;

  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_wr_en;
  logic        w_illegal;
  logic        w_accept;

  assign w_accept = bus.req_valid_i && (r_state == ST_IDLE);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req_valid_i) w_next = ST_READ;
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  if (bus.resp_ready_i) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request fields latched on accept; old CSR value captured in READ
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_funct3  <= '0;
      r_csr     <= '0;
      r_rs1_idx <= '0;
      r_rs1_val <= '0;
      r_rd_idx  <= '0;
      r_old     <= '0;
    end else begin
      if (w_accept) begin
        r_funct3  <= bus.req_funct3_i;
        r_csr     <= bus.req_csr_i;
        r_rs1_idx <= bus.req_rs1_idx_i;
        r_rs1_val <= bus.req_rs1_val_i;
        r_rd_idx  <= bus.req_rd_idx_i;
      end
      if (r_state == ST_READ) r_old <= bus.csr_out_i;
    end
  end

  // Operand select, new-value computation, write enable and legality
  always_comb begin
    w_src = r_funct3[2] ? {27'b0, r_rs1_idx} : r_rs1_val;
    w_new = '0;
    case (r_funct3[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = r_old | w_src;
      2'b11:   w_new = r_old & ~w_src;
      default: w_new = '0;
    endcase
    // set/clear with a zero source leave the CSR untouched
    w_wr_en   = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    w_illegal = (r_funct3[1:0] == 2'b00) ||
                (RO_CHECK && (r_csr[11:10] == 2'b11) && w_wr_en);
  end

  assign bus.req_ready_o = (r_state == ST_IDLE);
  assign bus.csr_rs_o    = r_csr;
  assign bus.csr_rd_o    = r_csr;
  // Strobe is masked by reset so an aborted WRITE never reaches the CSR file
  assign bus.csr_we_o    = (r_state == ST_WRITE) && w_wr_en && !w_illegal && !reset_i;
  assign bus.csr_in_o    = bus.csr_we_o ? w_new : '0;

  assign bus.resp_valid_o   = (r_state == ST_RESP);
  assign bus.resp_rd_idx_o  = r_rd_idx;
  assign bus.resp_data_o    = r_old;
  assign bus.resp_illegal_o = (r_state == ST_RESP) && w_illegal;
  assign bus.resp_rd_we_o   = (r_state == ST_RESP) && !w_illegal && (r_rd_idx != 5'd0);

endmodule

// File: doc/csr_exec.md
CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 Parameter RO_CHECK, default 1; when 1, any write attempt to CSR address bits [11:10]==2'b11 (read-only space) is flagged illegal.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 req_valid_i  in  1  CSR instruction request valid.
REQ-005 req_ready_o  out  1  unit can accept a request.
REQ-006 req_funct3_i  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI; 000/100 illegal.
REQ-007 req_csr_i  in  12  CSR address.
REQ-008 req_rs1_idx_i  in  5  rs1 index; also the zimm field for the immediate forms.
REQ-009 req_rs1_val_i  in  32  rs1 register value.
REQ-010 req_rd_idx_i  in  5  destination register index.
REQ-011 csr_rs_o  out  12  CSR read address to the CSR file.
REQ-012 csr_out_i  in  32  CSR read data, combinational from csr_rs_o.
REQ-013 csr_rd_o  out  12  CSR write address.
REQ-014 csr_in_o  out  32  CSR write data.
REQ-015 csr_we_o  out  1  CSR write strobe, one cycle.
REQ-016 resp_valid_o  out  1  writeback result valid.
REQ-017 resp_ready_i  in  1  writeback accepts the result.
REQ-018 resp_rd_idx_o  out  5  destination index.
REQ-019 resp_data_o  out  32  old CSR value.
REQ-020 resp_rd_we_o  out  1  register write enable; 1 iff rd!=0 and not illegal.
REQ-021 resp_illegal_o  out  1  illegal-instruction flag.

Function
REQ-022 FSM states: IDLE, READ, WRITE, RESP; req_ready_o=1 only in IDLE.
REQ-023 IDLE: on req_valid_i&&req_ready_o, latch funct3, csr, rs1_idx, rs1_val and rd_idx; go to READ.
REQ-024 READ: drive csr_rs_o=latched csr; capture csr_out_i into old_q at the clock edge; go to WRITE.
REQ-025 Operand: src = {27'b0, rs1_idx} when funct3[2]=1, else rs1_val.
REQ-026 New value: W forms new=src; S forms new=old_q|src; C forms new=old_q&~src.
REQ-027 Write suppression: S/C forms with rs1_idx==0 perform no write; W forms always write, including when rd==0.
REQ-028 Illegal when funct3 is 000/100, or when RO_CHECK=1 and csr[11:10]==2'b11 and a write is not suppressed.
REQ-029 WRITE: csr_rd_o=latched csr, csr_in_o=new, csr_we_o=1 for exactly this cycle iff write enabled and not illegal; go to RESP.
REQ-030 RESP: resp_valid_o=1; resp_data_o, resp_rd_idx_o, resp_rd_we_o and resp_illegal_o stay stable until resp_ready_i; on resp_valid_o&&resp_ready_i go to IDLE.
REQ-031 Latency: accept to first resp_valid_o is exactly 3 cycles; minimum initiation interval is 4 cycles; no overlap of requests.
REQ-032 csr_we_o=0 in every state other than WRITE.
REQ-033 csr_rs_o and csr_rd_o hold the latched address outside READ/WRITE (no glitch requirement); csr_in_o=0 when csr_we_o=0.
REQ-034 resp_valid_o is not gated by resp_ready_i; resp_ready_i held high gives a one-cycle RESP.
REQ-035 A request held on req_valid_i outside IDLE is ignored and is not latched.

Reset
REQ-036 While reset_i=1 at a clock edge: state=IDLE, old_q=0, all latched fields=0.
REQ-037 After reset: req_ready_o=1, resp_valid_o=0, csr_we_o=0, resp_illegal_o=0, resp_rd_we_o=0.
REQ-038 Reset in any state, including RESP with resp_ready_i=0, aborts the operation; no csr_we_o follows it and the response is dropped.

Verification
REQ-039 CSRRS rd=5, rs1_idx=0, csr=0xC00, csr_out_i=0x12 in READ -> csr_we_o never 1; resp_data_o=0x12, resp_rd_we_o=1, resp_illegal_o=0; resp_valid_o 3 cycles after accept.
REQ-040 CSRRW csr=0x340, rs1_val=0xDEADBEEF, rd=0, old=0x5 -> in WRITE cycle csr_rd_o=0x340, csr_in_o=0xDEADBEEF, csr_we_o=1; resp_rd_we_o=0, resp_data_o=0x5.
REQ-041 CSRRCI csr=0x300, zimm=0x3, old=0xFF -> csr_in_o=0xFC with csr_we_o=1; CSRRSI zimm=0x10, old=0x01 -> csr_in_o=0x11.
REQ-042 CSRRW csr=0xC80 with RO_CHECK=1 -> csr_we_o stays 0; resp_illegal_o=1, resp_rd_we_o=0. funct3=100 -> same response.
REQ-043 Backpressure: resp_ready_i=0 for 5 cycles -> resp_valid_o and all payload stable; req_ready_o=0; a second req_valid_i is not accepted until the cycle after the response handshake.
REQ-044 Assert reset_i during WRITE and during RESP -> next cycle req_ready_o=1, resp_valid_o=0, csr_we_o=0, and no extra write occurs.
